// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and constants for the branch predictor/recovery
//                controller: 2-bit saturating counter type, its four named
//                values, the controller state enum and the counter update rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t SNT = 2'b00;  // strong not-taken
    localparam ctr2_t WNT = 2'b01;  // weak not-taken (reset value)
    localparam ctr2_t WT  = 2'b10;  // weak taken
    localparam ctr2_t ST  = 2'b11;  // strong taken

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bc_state_t;

    // Saturating step toward the resolved outcome.
    function automatic ctr2_t ctr2_next(input ctr2_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr2_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr2_t'(c - 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_pht.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pht
//  Description : Pattern history table of 2^IDXW two-bit saturating counters.
//                One asynchronous read port, one synchronous update port.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_rd_idx        - lookup index
//                o_rd_ctr        - counter at i_rd_idx (pre-update value)
//                i_wr_en         - apply a training update this edge
//                i_wr_idx        - entry to train
//                i_wr_taken      - resolved outcome used for training
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_pht
    import branch_pkg::*;
#(
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] i_rd_idx,
    output ctr2_t           o_rd_ctr,
    input  logic            i_wr_en,
    input  logic [IDXW-1:0] i_wr_idx,
    input  logic            i_wr_taken
);

    localparam int c_entries = 2 ** IDXW;

    ctr2_t r_table [c_entries];

    // Read is straight from the array: a write at the same index this cycle
    // only becomes visible after the edge.
    assign o_rd_ctr = r_table[i_rd_idx];

    generate
        for (genvar gi = 0; gi < c_entries; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_table[gi] <= WNT;
                end else if (i_wr_en && (i_wr_idx == IDXW'(gi))) begin
                    r_table[gi] <= ctr2_next(r_table[gi], i_wr_taken);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : BLT branch predictor and mispredict recovery controller.
//                Predicts at fetch from a 2-bit counter PHT, trains the PHT
//                at resolve, and on a mispredict raises flush for
//                FLUSH_CYCLES cycles while redirecting the PC once.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                stall               - freezes all state
//                fetch_*             - fetch-stage instruction info
//                predict_taken       - combinational prediction
//                next_pc             - PC to load at the next edge
//                ex_*, branch_actual - resolving branch info
//                flush               - squash younger stages (registered)
//                branch_count        - resolved branches (registered)
//                mispredict_count    - mispredicted branches (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int PCW          = 8,
    parameter int IDXW         = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           fetch_valid,
    input  logic [PCW-1:0] fetch_pc,
    input  logic           fetch_is_blt,
    input  logic [PCW-1:0] fetch_target,
    output logic           predict_taken,
    output logic [PCW-1:0] next_pc,
    input  logic           ex_valid,
    input  logic [PCW-1:0] ex_pc,
    input  logic           ex_pred_taken,
    input  logic [PCW-1:0] ex_target,
    input  logic           branch_actual,
    output logic           flush,
    output logic [15:0]    branch_count,
    output logic [15:0]    mispredict_count
);

    localparam int c_cnt_w = $clog2(FLUSH_CYCLES + 1);

    bc_state_t          r_state;
    logic [c_cnt_w-1:0] r_flush_cnt;
    logic               r_first;        // first cycle of FLUSH: redirect now
    logic [PCW-1:0]     r_redirect_pc;
    logic               r_flush;
    logic [15:0]        r_branch_count;
    logic [15:0]        r_mispredict_count;

    ctr2_t              w_fetch_ctr;
    logic               w_resolve;
    logic               w_mispredict;

    // Wrong-path branches arriving during FLUSH must not train or count.
    assign w_resolve    = (r_state == RUN) && ex_valid && !stall;
    assign w_mispredict = w_resolve && (branch_actual != ex_pred_taken);

    bp_pht #(
        .IDXW (IDXW)
    ) u_pht (
        .clk        (clk),
        .rst        (reset),
        .i_rd_idx   (fetch_pc[IDXW-1:0]),
        .o_rd_ctr   (w_fetch_ctr),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (ex_pc[IDXW-1:0]),
        .i_wr_taken (branch_actual)
    );

    assign predict_taken = fetch_valid && fetch_is_blt && w_fetch_ctr[1];

    always_comb begin
        next_pc = fetch_pc + PCW'(1);
        if ((r_state == FLUSH) && r_first) begin
            next_pc = r_redirect_pc;
        end else if (predict_taken) begin
            next_pc = fetch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= RUN;
            r_flush_cnt        <= '0;
            r_first            <= 1'b0;
            r_redirect_pc      <= '0;
            r_flush            <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (!stall) begin
            case (r_state)
                RUN: begin
                    if (ex_valid) begin
                        r_branch_count <= r_branch_count + 16'd1;
                        if (w_mispredict) begin
                            r_mispredict_count <= r_mispredict_count + 16'd1;
                            r_redirect_pc      <= branch_actual ? ex_target
                                                                : ex_pc + PCW'(1);
                            r_flush_cnt        <= c_cnt_w'(FLUSH_CYCLES);
                            r_first            <= 1'b1;
                            r_flush            <= 1'b1;
                            r_state            <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    r_first <= 1'b0;
                    if (r_flush_cnt <= c_cnt_w'(1)) begin
                        r_flush_cnt <= '0;
                        r_flush     <= 1'b0;
                        r_state     <= RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign flush            = r_flush;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_ctrl
//  Description : Self-checking bench for branch_ctrl: directed scenarios with
//                fixed expectations, then randomized traffic compared against
//                an integer-level behavioural model of the predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    localparam int PCW = 8;
    localparam int IDXW = 4;
    localparam int FC = 2;

    logic        clk;
    logic        reset, stall;
    logic        fetch_valid, fetch_is_blt;
    logic [7:0]  fetch_pc, fetch_target;
    logic        predict_taken;
    logic [7:0]  next_pc;
    logic        ex_valid, ex_pred_taken, branch_actual;
    logic [7:0]  ex_pc, ex_target;
    logic        flush;
    logic [15:0] branch_count, mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pht [16];
    int m_bc, m_mc, m_left, m_redir;
    bit m_first;

    branch_ctrl #(.PCW(PCW), .IDXW(IDXW), .FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_is_blt     (fetch_is_blt),
        .fetch_target     (fetch_target),
        .predict_taken    (predict_taken),
        .next_pc          (next_pc),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_target        (ex_target),
        .branch_actual    (branch_actual),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_pred();
        return (fetch_valid && fetch_is_blt && m_pht[int'(fetch_pc) % 16] >= 2) ? 1 : 0;
    endfunction

    function automatic int exp_next();
        if (m_first) return m_redir;
        if (exp_pred() == 1) return int'(fetch_target);
        return (int'(fetch_pc) + 1) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_bc = 0; m_mc = 0; m_left = 0; m_first = 0; m_redir = 0;
    endtask

    // Advance the model across one clock edge using the inputs present at it.
    task automatic model_edge();
        int idx;
        if (reset) begin
            model_reset();
        end else if (!stall) begin
            if (m_left > 0) begin
                m_left--;
                m_first = 0;
            end else if (ex_valid) begin
                m_bc = (m_bc + 1) % 65536;
                idx  = int'(ex_pc) % 16;
                if (branch_actual) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
                else               m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
                if (branch_actual != ex_pred_taken) begin
                    m_mc    = (m_mc + 1) % 65536;
                    m_redir = branch_actual ? int'(ex_target) : (int'(ex_pc) + 1) % 256;
                    m_left  = FC;
                    m_first = 1;
                end
            end
        end
    endtask

    // Compare everything against the model mid-cycle, then take one edge.
    task automatic cycle();
        @(negedge clk);
        chk("m_pred",  int'(predict_taken),    exp_pred());
        chk("m_next",  int'(next_pc),          exp_next());
        chk("m_flush", int'(flush),            (m_left > 0) ? 1 : 0);
        chk("m_bc",    int'(branch_count),     m_bc);
        chk("m_mc",    int'(mispredict_count), m_mc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_fetch(input bit v, input bit blt, input int pc, input int tgt);
        fetch_valid  = v;
        fetch_is_blt = blt;
        fetch_pc     = 8'(pc);
        fetch_target = 8'(tgt);
    endtask

    task automatic set_ex(input bit v, input int pc, input bit pred, input bit act, input int tgt);
        ex_valid      = v;
        ex_pc         = 8'(pc);
        ex_pred_taken = pred;
        branch_actual = act;
        ex_target     = 8'(tgt);
    endtask

    initial begin
        int flush_high;

        reset = 1'b1; stall = 1'b0;
        set_fetch(0, 0, 0, 0);
        set_ex(0, 0, 0, 0, 0);
        @(posedge clk);
        model_reset();
        #1;
        cycle();
        reset = 1'b0;

        // Reset state and first fetch of an untrained BLT
        set_fetch(1, 1, 8'h05, 8'h20);
        #1;
        chk("rst_pred",  int'(predict_taken), 0);
        chk("rst_next",  int'(next_pc), 8'h06);
        chk("rst_flush", int'(flush), 0);
        chk("rst_bc",    int'(branch_count), 0);
        chk("rst_mc",    int'(mispredict_count), 0);
        cycle();

        // Mispredict: taken while predicted not-taken
        set_ex(1, 8'h05, 0, 1, 8'h20);
        cycle();
        set_ex(0, 0, 0, 0, 0);
        #1;
        chk("mp_flush1", int'(flush), 1);
        chk("mp_redir",  int'(next_pc), 8'h20);
        chk("mp_mc",     int'(mispredict_count), 1);
        chk("mp_bc",     int'(branch_count), 1);
        cycle();
        chk("mp_flush2", int'(flush), 1);
        chk("mp_pred10", int'(predict_taken), 1);
        cycle();
        chk("mp_flush3", int'(flush), 0);

        // Three correct taken resolves, then a not-taken mispredict
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 8'h05, 1, 1, 8'h20);
            cycle();
        end
        set_ex(1, 8'h05, 1, 0, 8'h20);
        cycle();
        #1;
        chk("nt_flush", int'(flush), 1);
        chk("nt_redir", int'(next_pc), 8'h06);
        chk("nt_bc",    int'(branch_count), 5);
        chk("nt_mc",    int'(mispredict_count), 2);

        // ex_valid during both FLUSH cycles is wrong-path and ignored
        set_ex(1, 8'h05, 1, 0, 8'h33);
        cycle();
        cycle();
        set_ex(0, 0, 0, 0, 0);
        #1;
        chk("wp_flush", int'(flush), 0);
        chk("wp_bc",    int'(branch_count), 5);
        chk("wp_pred",  int'(predict_taken), 1);  // PHT[5] still 10

        // Stall for three cycles inside FLUSH
        set_ex(1, 8'h05, 0, 1, 8'h40);
        cycle();
        set_ex(0, 0, 0, 0, 0);
        flush_high = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (flush) flush_high++;
            stall = (i >= 1 && i <= 3);
            cycle();
        end
        stall = 1'b0;
        chk("stall_flush_len", flush_high, FC + 3);

        // Reset during the first FLUSH cycle
        set_ex(1, 8'h05, 1, 0, 8'h40);
        cycle();
        set_ex(0, 0, 0, 0, 0);
        #1;
        chk("rf_flush_on", int'(flush), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_fetch(1, 0, 8'hFF, 8'h10);
        #1;
        chk("rf_flush_off", int'(flush), 0);
        chk("rf_wrap",      int'(next_pc), 8'h00);
        chk("rf_bc",        int'(branch_count), 0);
        chk("rf_mc",        int'(mispredict_count), 0);
        for (int i = 0; i < 16; i++) begin
            set_fetch(1, 1, i, 8'h80);
            #1;
            chk("rf_pht_wnt", int'(predict_taken), 0);
        end
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 9) == 0);
            set_fetch($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                      $urandom_range(0, 255), $urandom_range(0, 255));
            set_ex($urandom_range(0, 2) != 0,
                   ($urandom_range(0, 15) << 4) | $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 255));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-prediction and recovery controller for the picoMIPS pipeline. At fetch it predicts `BLT` outcomes from a table of 2-bit saturating counters and supplies the next PC. At the resolve stage it compares the predecoded prediction with the decoder's `branch_actual`, trains the table, and on a mispredict drives a multi-cycle flush and PC redirect. It sits beside the fetch/PC logic and consumes the decoder's branch output.

## Interface
Parameters:
- `PCW`, 8, program-counter width in bits
- `IDXW`, 4, PHT index width; the table has 2^IDXW entries indexed by `pc[IDXW-1:0]`
- `FLUSH_CYCLES`, 2, number of cycles `flush` stays high after a mispredict (fetch-to-resolve depth); must be ≥1

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  global pipeline stall; freezes all state
- `fetch_valid`  in  1  fetch stage holds a valid instruction
- `fetch_pc`  in  PCW  address of the fetched instruction
- `fetch_is_blt`  in  1  predecode: fetched opcode is `BLT`
- `fetch_target`  in  PCW  taken target computed at fetch
- `predict_taken`  out  1  combinational prediction for `fetch_pc`, gated by `fetch_valid & fetch_is_blt`
- `next_pc`  out  PCW  PC to load at the next edge
- `ex_valid`  in  1  a `BLT` is resolving this cycle
- `ex_pc`  in  PCW  PC of the resolving branch
- `ex_pred_taken`  in  1  prediction carried down the pipe with the branch
- `ex_target`  in  PCW  taken target of the resolving branch
- `branch_actual`  in  1  resolved outcome from the decoder
- `flush`  out  1  squash the younger pipeline stages (registered)
- `branch_count`  out  16  resolved branches (registered)
- `mispredict_count`  out  16  mispredicted branches (registered)

## Operation
- PHT entry encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken. The prediction is the entry's MSB. All entries reset to 01.
- `next_pc` is selected in this priority order:
  - `redirect_pc` in the first FLUSH cycle
  - `fetch_target` when `predict_taken` is 1
  - `fetch_pc+1` otherwise
- PC arithmetic is modulo 2^PCW; `fetch_pc` = all ones wraps to 0.
- Resolve happens only in RUN with `ex_valid & !stall`:
  - increment `branch_count`
  - update `PHT[ex_pc]`: increment if `branch_actual`, decrement otherwise, saturating at 00 and 11
  - a mispredict is `branch_actual != ex_pred_taken`
- On a mispredict:
  - increment `mispredict_count`
  - latch `redirect_pc` = `ex_target` if `branch_actual`, else `ex_pc+1`
  - go to FLUSH
- FSM states:
  - RUN → FLUSH on mispredict
  - FLUSH counts down `FLUSH_CYCLES`, then returns to RUN
  - In FLUSH, `ex_valid` is ignored: the branch is wrong-path, so there is no update and no count
- Both statistics counters wrap at 2^16.
- `stall` = 1 holds the FSM, the flush counter, the PHT and the statistics unchanged. Outputs stay at their held values.

## Timing
- `predict_taken` and `next_pc` are combinational, with zero latency from the fetch inputs.
- A PHT write lands at the edge closing the resolve cycle. A same-cycle lookup of the same index sees the old value (no bypass).
- A mispredict resolved in cycle T gives:
  - `flush` = 1 in cycles T+1 … T+FLUSH_CYCLES
  - `next_pc` = `redirect_pc` in cycle T+1
- A second mispredict cannot start during FLUSH.
- Reset values:
  - state RUN, flush count 0, `flush` 0
  - counters 0, all PHT entries 01
  - `predict_taken` 0 after reset, since entries are 01
- Reset asserted mid-FLUSH deasserts `flush` at the next edge. The redirect is dropped.

## Structure
- Shared package `branch_pkg`:
  - `ctr2_t` (2-bit counter)
  - `bc_state_t` enum {RUN, FLUSH}
  - counter constants `SNT`, `WNT`, `WT`, `ST`
- The `BLT` opcode comes from the existing opcodes include.
- Sub-module `bp_pht`:
  - a 2^IDXW × 2-bit register array
  - one asynchronous read port and one synchronous saturating-update port, with synchronous reset to `WNT`

## Test plan
- Reset, then fetch a `BLT` at pc=0x05 with target 0x20 → `predict_taken`=0, `next_pc`=0x06; both counters 0, `flush`=0.
- Resolve pc=0x05 taken with pred=0, target=0x20 → `flush` high for 2 cycles, `next_pc`=0x20 in cycle T+1, `mispredict_count`=1, PHT[5]=10; a following fetch at 0x05 predicts taken.
- Resolve pc=0x05 taken three times in RUN → PHT[5] saturates at 11; then one not-taken with pred=1 → redirect to 0x06, PHT[5]=10.
- Assert `ex_valid` on both FLUSH cycles → no PHT change, `branch_count` unchanged; RUN resumes in cycle T+3.
- Assert `stall` during FLUSH for 3 cycles → `flush` stays high and the countdown resumes afterwards; total `flush`-high = 2 unstalled cycles + 3.
- Reset in the first FLUSH cycle → `flush`=0 next cycle, all PHT entries 01, counters 0; `fetch_pc`=0xFF non-branch gives `next_pc`=0x00.
